// File: rtl/i2c_pkg.sv
// Shared types and widths for the I2C target.
package i2c_pkg;

  localparam int unsigned I2C_ADDR_W = 7;
  localparam int unsigned I2C_BYTE_W = 8;
  localparam int unsigned I2C_CNT_W  = $clog2(I2C_BYTE_W);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_IGNORE
  } i2c_tgt_state_t;

  // Read-byte load phase inside RD_DATA.
  typedef enum logic [1:0] {
    LD_DONE,
    LD_REQ,
    LD_WAIT,
    LD_REL
  } i2c_ld_t;

endpackage

// File: rtl/i2c_sync_edge.sv
// Synchronizes SCL/SDA into clk and flags SCL edges plus START/STOP.
module i2c_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic scl_meta, scl_sync, scl_prev;
  logic sda_meta, sda_sync, sda_prev;

  // Sync flops reset to the idle-bus level so release never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_meta  <= 1'b1;
      scl_sync  <= 1'b1;
      scl_prev  <= 1'b1;
      sda_meta  <= 1'b1;
      sda_sync  <= 1'b1;
      sda_prev  <= 1'b1;
      scl_rise  <= 1'b0;
      scl_fall  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
      sda_s     <= 1'b1;
    end else begin
      scl_meta  <= scl_in;
      scl_sync  <= scl_meta;
      scl_prev  <= scl_sync;
      sda_meta  <= sda_in;
      sda_sync  <= sda_meta;
      sda_prev  <= sda_sync;
      scl_rise  <= scl_sync & ~scl_prev;
      scl_fall  <= ~scl_sync & scl_prev;
      start_det <= scl_sync & scl_prev & sda_prev & ~sda_sync;
      stop_det  <= scl_sync & scl_prev & ~sda_prev & sda_sync;
      sda_s     <= sda_sync;
    end
  end

endmodule

// File: rtl/i2c_target.sv
// I2C target: address match, ACK, byte write/read to local logic.
// Optional SCL stretching on reads with I2C_TARGET_CLK_STRETCH_EN.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] ADDRESS = 7'h27
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sclk,
  input  logic                  sda_in,
  output logic                  sda_oe,
  output logic                  scl_oe,
  output logic [I2C_BYTE_W-1:0] wr_data,
  output logic                  wr_valid,
  input  logic                  wr_ready,
  output logic                  rd_req,
  input  logic [I2C_BYTE_W-1:0] rd_data,
  input  logic                  rd_valid,
  output logic                  busy
);

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_sync_edge u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_in    (sclk),
    .sda_in    (sda_in),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  i2c_tgt_state_t        state_q, state_d;
  i2c_ld_t               ld_q, ld_d;
  logic [I2C_CNT_W-1:0]  cnt_q, cnt_d;
  logic [I2C_BYTE_W-1:0] sh_q, sh_d, wr_data_q, wr_data_d, byte_in;
  logic rw_q, rw_d, ack_q, ack_d, wr_ok_q, wr_ok_d;
  logic sda_oe_q, sda_oe_d, scl_oe_q, scl_oe_d;
  logic wr_valid_q, wr_valid_d, rd_req_q, rd_req_d, busy_q, busy_d;
  logic cap;

`ifndef I2C_TARGET_CLK_STRETCH_EN
  logic unused_rd_valid;
  assign unused_rd_valid = rd_valid;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ld_q       <= LD_DONE;
      cnt_q      <= '0;
      sh_q       <= '0;
      wr_data_q  <= '0;
      rw_q       <= 1'b0;
      ack_q      <= 1'b0;
      wr_ok_q    <= 1'b0;
      sda_oe_q   <= 1'b0;
      scl_oe_q   <= 1'b0;
      wr_valid_q <= 1'b0;
      rd_req_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ld_q       <= ld_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      wr_data_q  <= wr_data_d;
      rw_q       <= rw_d;
      ack_q      <= ack_d;
      wr_ok_q    <= wr_ok_d;
      sda_oe_q   <= sda_oe_d;
      scl_oe_q   <= scl_oe_d;
      wr_valid_q <= wr_valid_d;
      rd_req_q   <= rd_req_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ld_d       = ld_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    wr_data_d  = wr_data_q;
    rw_d       = rw_q;
    ack_d      = ack_q;
    wr_ok_d    = wr_ok_q;
    sda_oe_d   = sda_oe_q;
    scl_oe_d   = scl_oe_q;
    wr_valid_d = 1'b0;
    rd_req_d   = 1'b0;
    busy_d     = busy_q;
    cap        = 1'b0;
    byte_in    = {sh_q[I2C_BYTE_W-2:0], sda_s};

    if (start_det || stop_det) begin
      state_d  = start_det ? ST_ADDR : ST_IDLE;
      cnt_d    = '0;
      ld_d     = LD_DONE;
      ack_d    = 1'b0;
      sda_oe_d = 1'b0;
      scl_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_ADDR: if (scl_rise) begin
          sh_d  = byte_in;
          cnt_d = cnt_q + I2C_CNT_W'(1);
          if (cnt_q == I2C_CNT_W'(I2C_BYTE_W - 1)) begin
            if (byte_in[I2C_BYTE_W-1:1] == ADDRESS) begin
              state_d = ST_ADDR_ACK;
              rw_d    = byte_in[0];
              busy_d  = 1'b1;
            end else begin
              state_d = ST_IGNORE;
            end
          end
        end
        // First SCL fall drives the ACK, the second ends the slot.
        ST_ADDR_ACK: if (scl_fall) begin
          if (!ack_q) begin
            sda_oe_d = 1'b1;
            ack_d    = 1'b1;
          end else begin
            sda_oe_d = 1'b0;
            ack_d    = 1'b0;
            if (rw_q) begin
              state_d  = ST_RD_DATA;
              rd_req_d = 1'b1;
              ld_d     = LD_REQ;
            end else begin
              state_d = ST_WR_DATA;
            end
          end
        end
        ST_WR_DATA: if (scl_rise) begin
          sh_d  = byte_in;
          cnt_d = cnt_q + I2C_CNT_W'(1);
          if (cnt_q == I2C_CNT_W'(I2C_BYTE_W - 1)) begin
            wr_data_d  = byte_in;
            wr_ok_d    = wr_ready;
            wr_valid_d = wr_ready;
            state_d    = ST_WR_ACK;
          end
        end
        ST_WR_ACK: if (scl_fall) begin
          if (!ack_q) begin
            sda_oe_d = wr_ok_q;
            ack_d    = 1'b1;
          end else begin
            sda_oe_d = 1'b0;
            ack_d    = 1'b0;
            state_d  = ST_WR_DATA;
          end
        end
        ST_RD_DATA: begin
          unique case (ld_q)
`ifdef I2C_TARGET_CLK_STRETCH_EN
            LD_REQ: if (rd_valid) begin
              cap = 1'b1;
            end else begin
              scl_oe_d = 1'b1;
              ld_d     = LD_WAIT;
            end
            LD_WAIT: cap = rd_valid;
`else
            LD_REQ:  ld_d = LD_WAIT;
            LD_WAIT: cap  = 1'b1;
`endif
            LD_REL: begin
              scl_oe_d = 1'b0;
              ld_d     = LD_DONE;
            end
            default: if (scl_fall) begin
              if (cnt_q == I2C_CNT_W'(I2C_BYTE_W - 1)) begin
                sda_oe_d = 1'b0;
                cnt_d    = '0;
                ack_d    = 1'b0;
                state_d  = ST_RD_ACK;
              end else begin
                sh_d     = {sh_q[I2C_BYTE_W-2:0], 1'b0};
                sda_oe_d = ~sh_q[I2C_BYTE_W-2];
                cnt_d    = cnt_q + I2C_CNT_W'(1);
              end
            end
          endcase
          // Load the byte and put its MSB on the line; a held SCL drops a cycle later.
          if (cap) begin
            sh_d     = rd_data;
            sda_oe_d = ~rd_data[I2C_BYTE_W-1];
            cnt_d    = '0;
            ld_d     = scl_oe_q ? LD_REL : LD_DONE;
          end
        end
        ST_RD_ACK: begin
          if (scl_rise) begin
            if (sda_s) begin
              state_d = ST_IGNORE;
              busy_d  = 1'b0;
            end else begin
              ack_d = 1'b1;
            end
          end else if (scl_fall && ack_q) begin
            ack_d    = 1'b0;
            state_d  = ST_RD_DATA;
            rd_req_d = 1'b1;
            ld_d     = LD_REQ;
          end
        end
        default: ;
      endcase
    end
  end

  assign sda_oe   = sda_oe_q;
  assign scl_oe   = scl_oe_q;
  assign wr_data  = wr_data_q;
  assign wr_valid = wr_valid_q;
  assign rd_req   = rd_req_q;
  assign busy     = busy_q;

endmodule
